mtr_spd_sequencer: RTL and testbench



---
 rtl/mtr_spd_sequencer_pkg.sv | 38 +++
 rtl/mtr_spd_sequencer_if.sv | 30 +++
 rtl/mtr_spd_sequencer_slew.sv | 49 ++++
 rtl/mtr_spd_sequencer.sv | 139 +++++++++++++
 tb/tb_mtr_spd_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mtr_spd_sequencer_pkg.sv
// rtl/mtr_spd_sequencer_pkg.sv - shared types, state encoding and defaults for the speed sequencer
//
// Package mtr_seq_pkg:
//   spd_t        11-bit signed wheel speed as consumed by MtrDrv
//   state_e      sequencer states IDLE / RAMP / HOLD / STOP
//   DEF_*        default slew, brake, clamp and watchdog constants
//   clamp_spd()  symmetric clamp of a signed speed to [-lim, lim]
package mtr_seq_pkg;

    typedef logic signed [10:0] spd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } state_e;

    localparam int DEF_STEP       = 16;
    localparam int DEF_BRAKE_STEP = 32;
    localparam int DEF_MAX_SPD    = 1023;
    localparam int DEF_TMO_PULSES = 2048;

    // -1024 is representable in spd_t but has no positive mirror, so the
    // clamp folds it to -lim to keep the speed range symmetric.
    function automatic spd_t clamp_spd(input spd_t v, input int lim);
        spd_t res;
        if (int'(v) > lim) begin
            res = spd_t'(lim);
        end else if (int'(v) < -lim) begin
            res = spd_t'(-lim);
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/mtr_spd_sequencer_if.sv
// rtl/mtr_spd_sequencer_if.sv - target-speed command handshake bundle
//
// Signals:
//   tgt_lft   signed target left speed
//   tgt_rght  signed target right speed
//   cmd_vld   target pair valid (master -> slave)
//   cmd_rdy   sequencer can accept a target (slave -> master)
interface mtr_spd_sequencer_if;
    import mtr_seq_pkg::*;

    spd_t tgt_lft;
    spd_t tgt_rght;
    logic cmd_vld;
    logic cmd_rdy;

    modport master (
        output tgt_lft,
        output tgt_rght,
        output cmd_vld,
        input  cmd_rdy
    );

    modport slave (
        input  tgt_lft,
        input  tgt_rght,
        input  cmd_vld,
        output cmd_rdy
    );

endinterface

// File: rtl/mtr_spd_sequencer_slew.sv
// rtl/mtr_spd_sequencer_slew.sv - single-wheel bounded-step slew toward a target
//
// Module spd_slew ports:
//   clk     system clock
//   rst_n   synchronous active-low reset (spd -> 0)
//   target  signed speed to approach
//   step    maximum magnitude change per enabled cycle
//   en      advance one step this cycle (otherwise spd holds)
//   spd     registered signed speed
module spd_slew
    import mtr_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  spd_t       target,
    input  logic [8:0] step,
    input  logic       en,
    output spd_t       spd
);

    logic signed [11:0] diff;
    logic        [11:0] mag;
    spd_t               spd_nxt;

    // The difference spans -2046..2046, so it is taken one bit wider than a
    // speed. Snapping to the target whenever |diff| <= step means the
    // stepped branch only runs when it cannot pass the target, which also
    // keeps the 11-bit add/subtract from wrapping.
    always_comb begin
        diff = {target[10], target} - {spd[10], spd};
        mag  = diff[11] ? 12'(-diff) : 12'(diff);
        if (mag <= {3'b000, step}) begin
            spd_nxt = target;
        end else if (diff[11]) begin
            spd_nxt = spd - spd_t'({2'b00, step});
        end else begin
            spd_nxt = spd + spd_t'({2'b00, step});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spd <= '0;
        end else if (en) begin
            spd <= spd_nxt;
        end
    end

endmodule

// File: rtl/mtr_spd_sequencer.sv
// rtl/mtr_spd_sequencer.sv - slew-limited wheel speed command sequencer in front of MtrDrv
//
// Optional feature macro: CMD_TMO_EN (command watchdog; tmo tied 0 when undefined)
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   cmd       target handshake (tgt_lft, tgt_rght, cmd_vld, cmd_rdy), slave side
//   pwm_sync  one-cycle pulse at start of each PWM period
//   estop     level emergency stop
//   lft_spd   signed speed to MtrDrv left
//   rght_spd  signed speed to MtrDrv right
//   at_tgt    both wheels at accepted target (HOLD)
//   busy      RAMP or STOP
//   tmo       sticky command-watchdog flag
module mtr_spd_sequencer
    import mtr_seq_pkg::*;
#(
    parameter int STEP       = DEF_STEP,
    parameter int BRAKE_STEP = DEF_BRAKE_STEP,
    parameter int MAX_SPD    = DEF_MAX_SPD,
    parameter int TMO_PULSES = DEF_TMO_PULSES
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    mtr_spd_sequencer_if.slave   cmd,
    input  logic                 pwm_sync,
    input  logic                 estop,
    output spd_t                 lft_spd,
    output spd_t                 rght_spd,
    output logic                 at_tgt,
    output logic                 busy,
    output logic                 tmo
);

    state_e     state;
    spd_t       tgt_l;
    spd_t       tgt_r;
    logic       accept;
    logic       tmo_fire;
    logic       slew_en;
    logic [8:0] step_sel;

    assign cmd.cmd_rdy = (state == IDLE) || (state == HOLD);
    assign at_tgt      = (state == HOLD);
    assign busy        = (state == RAMP) || (state == STOP);

    // estop on the same edge discards the command outright.
    assign accept = cmd.cmd_vld && cmd.cmd_rdy && !estop;

    // Slewing is gated by state, so an acceptance edge (IDLE/HOLD) never
    // moves the speeds even when pwm_sync coincides with it.
    assign slew_en  = pwm_sync && busy;
    assign step_sel = (state == STOP) ? 9'(BRAKE_STEP) : 9'(STEP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            tgt_l <= '0;
            tgt_r <= '0;
        end else if (estop) begin
            state <= STOP;
            tgt_l <= '0;
            tgt_r <= '0;
        end else if (accept) begin
            state <= RAMP;
            tgt_l <= clamp_spd(cmd.tgt_lft, MAX_SPD);
            tgt_r <= clamp_spd(cmd.tgt_rght, MAX_SPD);
        end else if (tmo_fire) begin
            state <= RAMP;
            tgt_l <= '0;
            tgt_r <= '0;
        end else begin
            case (state)
                RAMP: if (lft_spd == tgt_l && rght_spd == tgt_r) state <= HOLD;
                STOP: if (lft_spd == '0 && rght_spd == '0) state <= IDLE;
                default: ;
            endcase
        end
    end

`ifdef CMD_TMO_EN
    localparam int TMO_CW = $clog2(TMO_PULSES + 1);

    logic [TMO_CW-1:0] tmo_cnt;
    logic              tmo_q;
    logic              hold_armed;

    // Only a non-zero hold is watched; once the watchdog has ramped to zero
    // the resulting zero-target HOLD cannot re-fire.
    assign hold_armed = (state == HOLD) && (tgt_l != '0 || tgt_r != '0);
    assign tmo_fire   = hold_armed && pwm_sync && !estop && !accept &&
                        (tmo_cnt == TMO_CW'(TMO_PULSES - 1));
    assign tmo        = tmo_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            if (accept) begin
                tmo_q <= 1'b0;
            end else if (tmo_fire) begin
                tmo_q <= 1'b1;
            end
            if (accept || estop || tmo_fire || !hold_armed) begin
                tmo_cnt <= '0;
            end else if (pwm_sync) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    localparam int tmo_pulses_unused = TMO_PULSES;

    assign tmo_fire = 1'b0;
    assign tmo      = 1'b0;
`endif

    spd_slew u_slew_lft (
        .clk    (clk),
        .rst_n  (rst_n),
        .target (tgt_l),
        .step   (step_sel),
        .en     (slew_en),
        .spd    (lft_spd)
    );

    spd_slew u_slew_rght (
        .clk    (clk),
        .rst_n  (rst_n),
        .target (tgt_r),
        .step   (step_sel),
        .en     (slew_en),
        .spd    (rght_spd)
    );

endmodule

// File: tb/tb_mtr_spd_sequencer.sv
// tb/tb_mtr_spd_sequencer.sv - directed self-checking bench for mtr_spd_sequencer
module tb_mtr_spd_sequencer;
    import mtr_seq_pkg::*;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic pwm_sync = 1'b0;
    logic estop    = 1'b0;
    spd_t lft_spd;
    spd_t rght_spd;
    logic at_tgt;
    logic busy;
    logic tmo;

    int errors = 0;
    int checks = 0;

    mtr_spd_sequencer_if cmd ();

    mtr_spd_sequencer #(
        .STEP       (16),
        .BRAKE_STEP (32),
        .MAX_SPD    (1023),
        .TMO_PULSES (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .pwm_sync (pwm_sync),
        .estop    (estop),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .at_tgt   (at_tgt),
        .busy     (busy),
        .tmo      (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        pwm_sync = 1'b1;
        tick();
        pwm_sync = 1'b0;
    endtask

    task automatic send(input int l, input int r);
        cmd.tgt_lft  = spd_t'(l);
        cmd.tgt_rght = spd_t'(r);
        cmd.cmd_vld  = 1'b1;
        tick();
        cmd.cmd_vld  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int exp_l [4] = '{16, 32, 48, 64};
        int exp_r [4] = '{-16, -32, -40, -40};
        int n;

        // Reset with a command pending
        cmd.tgt_lft  = spd_t'(100);
        cmd.tgt_rght = spd_t'(100);
        cmd.cmd_vld  = 1'b1;
        idle(2);
        check("rst_lft", lft_spd, 0);
        check("rst_rght", rght_spd, 0);
        check("rst_rdy", cmd.cmd_rdy, 1);
        check("rst_busy", busy, 0);
        check("rst_at_tgt", at_tgt, 0);
        check("rst_tmo", tmo, 0);
        cmd.cmd_vld = 1'b0;
        rst_n = 1'b1;
        tick();
        check("rst_no_accept", busy, 0);

        // Ramp 64 / -40
        send(64, -40);
        check("acc_busy", busy, 1);
        check("acc_rdy", cmd.cmd_rdy, 0);
        check("acc_lft", lft_spd, 0);
        idle(3);
        for (int k = 0; k < 4; k++) begin
            pulse();
            check($sformatf("ramp_lft%0d", k), lft_spd, exp_l[k]);
            check($sformatf("ramp_rght%0d", k), rght_spd, exp_r[k]);
            check($sformatf("ramp_rdy%0d", k), cmd.cmd_rdy, 0);
            idle(3);
        end
        check("hold_at_tgt", at_tgt, 1);
        check("hold_rdy", cmd.cmd_rdy, 1);
        check("hold_busy", busy, 0);

        // Clamp, no-move on acceptance edge, freeze without pwm_sync
        pwm_sync = 1'b1;
        send(-1024, -40);
        pwm_sync = 1'b0;
        check("acc_sync_nomove", lft_spd, 64);
        check("acc_sync_busy", busy, 1);
        idle(3);
        pulse();
        check("clamp_step1", lft_spd, 48);
        idle(3);
        pulse();
        check("clamp_step2", lft_spd, 32);
        idle(20);
        check("nosync_frozen", lft_spd, 32);
        n = 0;
        while (!at_tgt && n < 100) begin
            pulse();
            idle(3);
            n++;
        end
        check("clamp_lft", lft_spd, -1023);
        check("clamp_rght", rght_spd, -40);
        check("clamp_at_tgt", at_tgt, 1);

        // Zero command from HOLD, then reset mid-ramp
        send(0, 0);
        idle(1);
        pulse();
        check("zero_ramp_lft", lft_spd, -1007);
        check("zero_ramp_rght", rght_spd, -24);
        rst_n = 1'b0;
        tick();
        check("midrst_lft", lft_spd, 0);
        check("midrst_rght", rght_spd, 0);
        check("midrst_rdy", cmd.cmd_rdy, 1);
        check("midrst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Estop while ramping toward 200
        send(200, 0);
        idle(3);
        for (int k = 0; k < 3; k++) begin
            pulse();
            idle(3);
        end
        check("es_pre_lft", lft_spd, 48);
        estop        = 1'b1;
        cmd.tgt_lft  = spd_t'(5);
        cmd.cmd_vld  = 1'b1;
        tick();
        check("es_busy", busy, 1);
        check("es_rdy", cmd.cmd_rdy, 0);
        check("es_lft_hold", lft_spd, 48);
        idle(2);
        pulse();
        check("es_brake1", lft_spd, 16);
        idle(3);
        pulse();
        check("es_brake2", lft_spd, 0);
        idle(3);
        pulse();
        idle(3);
        check("es_stay_lft", lft_spd, 0);
        check("es_stay_busy", busy, 1);
        estop       = 1'b0;
        cmd.cmd_vld = 1'b0;
        tick();
        check("es_idle_rdy", cmd.cmd_rdy, 1);
        check("es_idle_busy", busy, 0);
        check("es_idle_at_tgt", at_tgt, 0);

        // Estop and cmd_vld on the same edge from HOLD
        send(32, -32);
        idle(3);
        pulse();
        idle(3);
        pulse();
        idle(3);
        check("sim_hold", at_tgt, 1);
        cmd.tgt_lft = spd_t'(500);
        cmd.cmd_vld = 1'b1;
        estop       = 1'b1;
        tick();
        estop       = 1'b0;
        cmd.cmd_vld = 1'b0;
        check("sim_busy", busy, 1);
        check("sim_at_tgt", at_tgt, 0);
        check("sim_lft", lft_spd, 32);
        pulse();
        check("sim_brake_lft", lft_spd, 0);
        check("sim_brake_rght", rght_spd, 0);
        tick();
        check("sim_idle_rdy", cmd.cmd_rdy, 1);
        check("sim_idle_busy", busy, 0);

        // Watchdog behaviour in HOLD at 32
        send(32, 0);
        idle(3);
        pulse();
        idle(3);
        pulse();
        idle(3);
        check("wd_hold", at_tgt, 1);
        for (int k = 0; k < 7; k++) begin
            pulse();
            idle(3);
        end
        check("wd_pre_tmo", tmo, 0);
        check("wd_pre_at_tgt", at_tgt, 1);
        pulse();
`ifdef CMD_TMO_EN
        check("wd_tmo", tmo, 1);
        check("wd_busy", busy, 1);
        check("wd_lft", lft_spd, 32);
        idle(3);
        pulse();
        check("wd_ramp1", lft_spd, 16);
        idle(3);
        pulse();
        check("wd_ramp2", lft_spd, 0);
        idle(3);
        check("wd_zero_hold", at_tgt, 1);
        check("wd_sticky", tmo, 1);
        send(16, 0);
        check("wd_clear", tmo, 0);
`else
        check("wd_off_tmo", tmo, 0);
        check("wd_off_at_tgt", at_tgt, 1);
        idle(3);
        pulse();
        check("wd_off_lft", lft_spd, 32);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
